// File: rtl/bitty_control_unit_pkg.sv
// Shared types and constants for the BittyPro control unit.
// Holds the datapath widths, the instruction field positions, the format codes,
// the FSM state encodings and the decoded-field struct.
package bitty_control_unit_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned ALU_W     = 3;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // Instruction field positions
  localparam int unsigned RX_MSB  = 15;
  localparam int unsigned RX_LSB  = 13;
  localparam int unsigned RY_MSB  = 12;
  localparam int unsigned RY_LSB  = 10;
  localparam int unsigned IMM_MSB = 12;
  localparam int unsigned IMM_LSB = 5;
  localparam int unsigned ALU_MSB = 4;
  localparam int unsigned ALU_LSB = 2;
  localparam int unsigned FMT_MSB = 1;
  localparam int unsigned FMT_LSB = 0;

  localparam logic [1:0] FMT_RR  = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_S_LOAD = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef struct packed {
    logic [SEL_W-1:0] rx;
    logic [SEL_W-1:0] ry;
    logic [IMM_W-1:0] imm8;
    logic [ALU_W-1:0] alu;
    logic [1:0]       fmt;
    logic             is_illegal;
  } fields_t;

endpackage

// File: rtl/bitty_control_unit_if.sv
// Instruction handshake plus datapath control bundle.
// master: the control unit (takes instr/instr_valid/halt, drives ready and controls).
// slave : fetch + datapath side.
interface bitty_control_unit_if;
  import bitty_control_unit_pkg::*;

  logic [DATA_W-1:0]   instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                halt;
  logic [SEL_W-1:0]    mux_sel;
  logic                en_s;
  logic                en_c;
  logic                sel_imm;
  logic [DATA_W-1:0]   imm;
  logic [ALU_W-1:0]    alu_sel;
  logic [NUM_REGS-1:0] en_i;
  logic                done;
  logic                illegal;

  modport master (
    input  instr, instr_valid, halt,
    output instr_ready, mux_sel, en_s, en_c, sel_imm, imm, alu_sel, en_i, done, illegal
  );

  modport slave (
    output instr, instr_valid, halt,
    input  instr_ready, mux_sel, en_s, en_c, sel_imm, imm, alu_sel, en_i, done, illegal
  );
endinterface

// File: rtl/bitty_control_unit_decoder.sv
// Combinational field split of an instruction word.
// Ports: i_ir (instruction word) -> o_fields_c (rx, ry, imm8, alu, fmt, is_illegal).
module bitty_control_unit_decoder
  import bitty_control_unit_pkg::*;
(
  input  logic [DATA_W-1:0] i_ir,
  output fields_t           o_fields_c
);

  always_comb begin
    o_fields_c            = '0;
    o_fields_c.rx         = i_ir[RX_MSB:RX_LSB];
    o_fields_c.ry         = i_ir[RY_MSB:RY_LSB];
    o_fields_c.imm8       = i_ir[IMM_MSB:IMM_LSB];
    o_fields_c.alu        = i_ir[ALU_MSB:ALU_LSB];
    o_fields_c.fmt        = i_ir[FMT_MSB:FMT_LSB];
    o_fields_c.is_illegal = (o_fields_c.fmt != FMT_RR) && (o_fields_c.fmt != FMT_IMM);
  end

endmodule

// File: rtl/bitty_control_unit.sv
// BittyPro sequencer: accepts one instruction per handshake and steps the register-read
// mux, S/C load enables and one-hot register-file write enable through
// S_LOAD -> EXEC -> WB (or ERR for an unsupported format).
// Ports: clk, reset_n (async active-low), bus (bitty_control_unit_if.master),
//        instr_count (retired-instruction counter, wraps).
module bitty_control_unit
  import bitty_control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bitty_control_unit_if.master bus,
  output logic [CNT_W-1:0]     instr_count
);

  logic [2:0]          r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_ir, w_ir_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  fields_t             w_f;
  logic                w_accept;

  logic [SEL_W-1:0]    r_mux_sel, w_mux_sel_nxt;
  logic                r_en_s, w_en_s_nxt;
  logic                r_en_c, w_en_c_nxt;
  logic                r_sel_imm, w_sel_imm_nxt;
  logic [NUM_REGS-1:0] r_en_i, w_en_i_nxt;
  logic                r_done, w_done_nxt;
  logic                r_illegal, w_illegal_nxt;
  logic [DATA_W-1:0]   r_imm;
  logic [ALU_W-1:0]    r_alu;

  // Ready is gated by reset_n so nothing looks acceptable while reset is held
  assign bus.instr_ready = reset_n && (r_state == ST_IDLE) && !bus.halt;
  assign w_accept        = bus.instr_ready && bus.instr_valid;
  assign w_ir_nxt        = w_accept ? bus.instr : r_ir;

  // Decode the next IR so registered outputs line up with the state they belong to
  bitty_control_unit_decoder u_dec (
    .i_ir       (w_ir_nxt),
    .o_fields_c (w_f)
  );

  // Next state and next (registered) Moore outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_mux_sel_nxt = '0;
    w_en_s_nxt    = 1'b0;
    w_en_c_nxt    = 1'b0;
    w_sel_imm_nxt = 1'b0;
    w_en_i_nxt    = '0;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;

    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_f.is_illegal ? ST_ERR : ST_S_LOAD;
      ST_S_LOAD: w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_WB;
      ST_WB: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = r_count + CNT_W'(1);
      end
      ST_ERR:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_S_LOAD: begin
        w_mux_sel_nxt = w_f.rx;
        w_en_s_nxt    = 1'b1;
      end
      ST_EXEC: begin
        w_mux_sel_nxt = (w_f.fmt == FMT_RR) ? w_f.ry : '0;
        w_sel_imm_nxt = (w_f.fmt == FMT_IMM);
        w_en_c_nxt    = 1'b1;
      end
      ST_WB: begin
        w_en_i_nxt = NUM_REGS'(1) << w_f.rx;
        w_done_nxt = 1'b1;
      end
      ST_ERR:  w_illegal_nxt = 1'b1;
      default: ;
    endcase
  end

  // State, IR, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_count   <= '0;
      r_mux_sel <= '0;
      r_en_s    <= 1'b0;
      r_en_c    <= 1'b0;
      r_sel_imm <= 1'b0;
      r_en_i    <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_imm     <= '0;
      r_alu     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ir      <= w_ir_nxt;
      r_count   <= w_count_nxt;
      r_mux_sel <= w_mux_sel_nxt;
      r_en_s    <= w_en_s_nxt;
      r_en_c    <= w_en_c_nxt;
      r_sel_imm <= w_sel_imm_nxt;
      r_en_i    <= w_en_i_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
      r_imm     <= {{(DATA_W-IMM_W){1'b0}}, w_f.imm8};
      r_alu     <= w_f.alu;
    end
  end

  assign bus.mux_sel  = r_mux_sel;
  assign bus.en_s     = r_en_s;
  assign bus.en_c     = r_en_c;
  assign bus.sel_imm  = r_sel_imm;
  assign bus.en_i     = r_en_i;
  assign bus.done     = r_done;
  assign bus.illegal  = r_illegal;
  assign bus.imm      = r_imm;
  assign bus.alu_sel  = r_alu;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_bitty_control_unit.sv
// Self-checking bench for bitty_control_unit: directed cases then random stimulus,
// compared each cycle against a queue-of-expected-cycles model.
module tb_bitty_control_unit;
  import bitty_control_unit_pkg::*;

  typedef struct packed {
    logic [2:0] mux;
    logic       en_s;
    logic       en_c;
    logic       sel_imm;
    logic [7:0] en_i;
    logic       done;
    logic       illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cnt;
  logic [3:0]  cnt_w;

  always #5 clk = ~clk;

  bitty_control_unit_if bus ();
  bitty_control_unit_if bus_w ();

  // Narrow-counter copy sees identical stimulus to exercise counter wrap cheaply
  assign bus_w.instr       = bus.instr;
  assign bus_w.instr_valid = bus.instr_valid;
  assign bus_w.halt        = bus.halt;

  bitty_control_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .instr_count (cnt)
  );

  bitty_control_unit #(.CNT_W(4)) u_wrap (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_w),
    .instr_count (cnt_w)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [15:0] m_cnt = '0;
  logic [15:0] m_ir  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs for one accepted instruction
  function automatic void model_accept(input logic [15:0] ins);
    exp_t e;
    logic [2:0] rx;
    logic [2:0] ry;
    rx = ins[15:13];
    ry = ins[12:10];
    m_ir = ins;
    if (ins[1]) begin
      e = '0; e.illegal = 1'b1; q.push_back(e);
    end else begin
      e = '0; e.mux = rx; e.en_s = 1'b1; q.push_back(e);
      e = '0; e.mux = (ins[0] == 1'b0) ? ry : 3'd0; e.en_c = 1'b1; e.sel_imm = ins[0];
      q.push_back(e);
      e = '0; e.en_i = 8'(1) << rx; e.done = 1'b1; q.push_back(e);
    end
  endfunction

  task automatic chk_outs(input exp_t e);
    logic [7:0] imm8;
    imm8 = m_ir[12:5];
    chk("mux_sel", 32'(bus.mux_sel), 32'(e.mux));
    chk("en_s", 32'(bus.en_s), 32'(e.en_s));
    chk("en_c", 32'(bus.en_c), 32'(e.en_c));
    chk("sel_imm", 32'(bus.sel_imm), 32'(e.sel_imm));
    chk("en_i", 32'(bus.en_i), 32'(e.en_i));
    chk("done", 32'(bus.done), 32'(e.done));
    chk("illegal", 32'(bus.illegal), 32'(e.illegal));
    chk("imm", 32'(bus.imm), {24'h0, imm8});
    chk("alu_sel", 32'(bus.alu_sel), 32'(m_ir[4:2]));
    chk("count", 32'(cnt), 32'(m_cnt));
    chk("count4", 32'(cnt_w), 32'(m_cnt[3:0]));
  endtask

  // One clock: check this cycle's outputs, then drive inputs for the next edge
  task automatic step(input logic v, input logic [15:0] ins, input logic h);
    exp_t e;
    logic cur_idle;
    @(negedge clk);
    cur_idle = (q.size() == 0);
    e = '0;
    if (!cur_idle) e = q.pop_front();
    chk_outs(e);
    if (e.done) m_cnt = m_cnt + 16'd1;
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.halt        = h;
    #1;
    chk("ready", 32'(bus.instr_ready), 32'(cur_idle && !h));
    if (cur_idle && v && !h) model_accept(ins);
  endtask

  // Async reset asserted mid-cycle; outputs must clear at once
  task automatic reset_now();
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    chk("rst_en_i", 32'(bus.en_i), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_count", 32'(cnt), 32'h0);
    q.delete();
    m_cnt = '0;
    m_ir  = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h7400;
    bus.halt        = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs('0);
    chk("ready_in_reset", 32'(bus.instr_ready), 32'h0);
    reset_n = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.instr_ready), 32'h1);

    // Reg-reg, immediate, illegal
    step(1'b1, 16'h7400, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h4545, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0002, 1'b0);
    repeat (2) step(1'b0, 16'h0000, 1'b0);

    // Valid held high: halt blocks accept in IDLE, but not an in-flight instruction
    repeat (3) step(1'b1, 16'h7400, 1'b1);
    step(1'b1, 16'h2405, 1'b0);
    step(1'b1, 16'h2405, 1'b0);
    repeat (3) step(1'b1, 16'h2405, 1'b1);
    step(1'b0, 16'h0000, 1'b0);

    // Reset during writeback
    step(1'b1, 16'hE000, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    reset_now();
    repeat (2) step(1'b0, 16'h0000, 1'b0);

    // Random traffic (enough retirements to wrap the 4-bit counter several times)
    repeat (600) step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 4) == 0));
    repeat (5) step(1'b0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
